// File: rtl/controlador_registrador_7bits_pkg.sv
// pkg_registrador: shared mode, width and state constants for the 7-bit shift register controller
package pkg_registrador;
  localparam int LARGURA = 7;
  typedef logic [1:0] modo_t;
  localparam modo_t MODO_HOLD = 2'b00;
  localparam modo_t MODO_DESLOCA = 2'b01;
  localparam modo_t MODO_CARGA = 2'b10;
  typedef logic [2:0] estado_t;
  localparam estado_t OCIOSO = 3'd0;
  localparam estado_t CARGA = 3'd1;
  localparam estado_t DESLOCA = 3'd2;
  localparam estado_t FIM = 3'd3;
  localparam estado_t PAUSA_ST = 3'd4;
endpackage

// File: rtl/controlador_registrador_7bits_if.sv
// controlador_registrador_7bits_if: request/ack/done handshake for both word sources
interface controlador_registrador_7bits_if;
  import pkg_registrador::*;
  logic req_a, req_b, ack_a, ack_b, fim_a, fim_b;
  logic [LARGURA-1:0] dado_a, dado_b;
  modport master (output req_a, req_b, dado_a, dado_b, input ack_a, ack_b, fim_a, fim_b);
  modport slave (input req_a, req_b, dado_a, dado_b, output ack_a, ack_b, fim_a, fim_b);
endinterface

// File: rtl/controlador_registrador_7bits_arbitro.sv
// arbitro_rr2: two-way round-robin grant, the requester not served last wins a tie
module arbitro_rr2 (
  input  logic req_a,
  input  logic req_b,
  input  logic ultimo,
  output logic concede_a,
  output logic concede_b
);
  assign concede_a = req_a & (~req_b | ultimo);
  assign concede_b = req_b & (~req_a | ~ultimo);
endmodule

// File: rtl/controlador_registrador_7bits.sv
// controlador_registrador_7bits: arbitrates two word sources, loads the winner into the shift register and streams it MSB-first
module controlador_registrador_7bits
  import pkg_registrador::*;
#(
  parameter int PAUSA = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  controlador_registrador_7bits_if.slave bus,
  output logic                   ch1,
  output logic                   ch0,
  output logic [LARGURA-1:0]     bits,
  output logic                   d,
  input  logic                   saida_ultimoflip,
  output logic                   serial_bit,
  output logic                   serial_valid,
  output logic                   ocupado
);
  estado_t est, nxt;
  modo_t modo;
  logic [3:0] cont;
  logic sel, ultimo, concede_a, concede_b;

  arbitro_rr2 u_arbitro (
    .req_a(bus.req_a),
    .req_b(bus.req_b),
    .ultimo(ultimo),
    .concede_a(concede_a),
    .concede_b(concede_b)
  );

  assign {ch1, ch0} = modo;
  assign d = 1'b0;
  assign serial_bit = serial_valid & saida_ultimoflip;

  // next state: one load cycle, seven shift cycles, one done cycle, optional pause
  always_comb begin
    nxt = est == OCIOSO ? (bus.req_a | bus.req_b ? CARGA : OCIOSO)
        : est == CARGA ? DESLOCA
        : est == DESLOCA ? (cont == 4'd6 ? FIM : DESLOCA)
        : est == FIM ? (PAUSA > 0 ? PAUSA_ST : OCIOSO)
        : (cont == 4'(PAUSA - 1) ? OCIOSO : PAUSA_ST);
  end

  // state, grant memory and outputs registered from the upcoming state so they line up with it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      est <= OCIOSO;
      cont <= 4'd0;
      sel <= 1'b0;
      ultimo <= 1'b1;
      modo <= MODO_HOLD;
      bits <= '0;
      bus.ack_a <= 1'b0;
      bus.ack_b <= 1'b0;
      bus.fim_a <= 1'b0;
      bus.fim_b <= 1'b0;
      serial_valid <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      est <= nxt;
      cont <= nxt == est && (est == DESLOCA || est == PAUSA_ST) ? cont + 4'd1 : 4'd0;
      sel <= est == OCIOSO ? concede_b : sel;
      ultimo <= est == CARGA ? sel : ultimo;
      modo <= nxt == CARGA ? MODO_CARGA : nxt == DESLOCA ? MODO_DESLOCA : MODO_HOLD;
      bits <= nxt == CARGA ? (concede_a ? bus.dado_a : bus.dado_b) : '0;
      bus.ack_a <= nxt == CARGA && concede_a;
      bus.ack_b <= nxt == CARGA && concede_b;
      bus.fim_a <= nxt == FIM && !sel;
      bus.fim_b <= nxt == FIM && sel;
      serial_valid <= nxt == DESLOCA;
      ocupado <= nxt != OCIOSO;
    end
  end
endmodule

// File: tb/tb_controlador_registrador_7bits.sv
// tb_controlador_registrador_7bits: directed scoreboard bench for the shift register controller
module tb_controlador_registrador_7bits;
  import pkg_registrador::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controlador_registrador_7bits_if b0();
  controlador_registrador_7bits_if b3();
  logic ch1_0, ch0_0, d_0, so_0, sb_0, sv_0, oc_0;
  logic ch1_3, ch0_3, d_3, so_3, sb_3, sv_3, oc_3;
  logic [6:0] bits_0, bits_3, q0, q3;

  controlador_registrador_7bits #(.PAUSA(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0), .ch1(ch1_0), .ch0(ch0_0), .bits(bits_0), .d(d_0),
    .saida_ultimoflip(so_0), .serial_bit(sb_0), .serial_valid(sv_0), .ocupado(oc_0)
  );
  controlador_registrador_7bits #(.PAUSA(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3), .ch1(ch1_3), .ch0(ch0_3), .bits(bits_3), .d(d_3),
    .saida_ultimoflip(so_3), .serial_bit(sb_3), .serial_valid(sv_3), .ocupado(oc_3)
  );

  // external universal shift registers driven by the controllers
  always @(posedge clk) q0 <= {ch1_0, ch0_0} == MODO_CARGA ? bits_0 : {ch1_0, ch0_0} == MODO_DESLOCA ? {q0[5:0], d_0} : q0;
  always @(posedge clk) q3 <= {ch1_3, ch0_3} == MODO_CARGA ? bits_3 : {ch1_3, ch0_3} == MODO_DESLOCA ? {q3[5:0], d_3} : q3;
  assign so_0 = q0[6];
  assign so_3 = q3[6];

  int n_cmp = 0;
  int n_err = 0;
  int bad_modo = 0;
  int nb = 0;
  logic [6:0] sh = '0;
  logic [7:0] exp0[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // collect each streamed word and compare it with the scoreboard when its done pulse appears
  always @(negedge clk) begin
    if ({ch1_0, ch0_0} === 2'b11 || {ch1_3, ch0_3} === 2'b11) bad_modo++;
    if (sv_0) begin
      sh = {sh[5:0], sb_0};
      nb++;
    end
    if (b0.fim_a || b0.fim_b) begin
      if (exp0.size() == 0) chk("fila_vazia_no_fim", exp0.size(), 1);
      else chk("palavra", {b0.fim_b, sh}, exp0.pop_front());
      chk("nbits", nb, 7);
      nb = 0;
    end
    if (!rst_n) nb = 0;
  end

  task automatic espera(input int qual, input int lim, output int cyc);
    logic hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < lim) begin
      @(posedge clk);
      #1;
      cyc++;
      hit = qual == 0 ? b0.ack_a : qual == 1 ? b0.ack_b : qual == 2 ? b0.fim_a : qual == 3 ? b0.fim_b : (b0.ack_a | b0.ack_b);
    end
    chk($sformatf("timeout_%0d", qual), hit, 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c, np;
    logic hit;
    {b0.req_a, b0.req_b, b3.req_a, b3.req_b} = '0;
    {b0.dado_a, b0.dado_b, b3.dado_a, b3.dado_b} = '0;
    repeat (2) step();
    chk("rst_modo", {ch1_0, ch0_0}, 0);
    chk("rst_bits", bits_0, 0);
    chk("rst_d", d_0, 0);
    chk("rst_ack", {b0.ack_a, b0.ack_b, b0.fim_a, b0.fim_b}, 0);
    chk("rst_valid", sv_0, 0);
    chk("rst_ocupado", oc_0, 0);
    chk("rst_serial", sb_0, 0);
    rst_n = 1'b1;
    step();
    b0.dado_a = 7'b1011001;
    b0.req_a = 1'b1;
    exp0.push_back({1'b0, 7'b1011001});
    step();
    chk("t1_ack_a", b0.ack_a, 1);
    chk("t1_ack_b", b0.ack_b, 0);
    chk("t1_modo_carga", {ch1_0, ch0_0}, 2);
    chk("t1_bits", bits_0, 7'b1011001);
    chk("t1_ocupado", oc_0, 1);
    b0.req_a = 1'b0;
    for (int k = 0; k < 7; k++) begin
      step();
      chk("t1_valid", sv_0, 1);
      chk("t1_modo_desloca", {ch1_0, ch0_0}, 1);
      chk("t1_bits_zero", bits_0, 0);
    end
    step();
    chk("t1_fim_a", b0.fim_a, 1);
    chk("t1_valid_off", sv_0, 0);
    chk("t1_modo_fim", {ch1_0, ch0_0}, 0);
    step();
    chk("t1_ocioso", oc_0, 0);
    rst_n = 1'b0;
    b0.dado_a = 7'b1100101;
    b0.dado_b = 7'b0000111;
    b0.req_a = 1'b1;
    b0.req_b = 1'b1;
    exp0.push_back({1'b0, 7'b1100101});
    exp0.push_back({1'b1, 7'b0000111});
    step();
    rst_n = 1'b1;
    step();
    chk("t2_ack_a", b0.ack_a, 1);
    chk("t2_ack_b", b0.ack_b, 0);
    b0.req_a = 1'b0;
    espera(2, 20, c);
    chk("t2_fim_a_lat", c, 8);
    espera(1, 5, c);
    chk("t2_ack_b_lat", c, 2);
    b0.req_b = 1'b0;
    espera(3, 20, c);
    chk("t2_fim_b_lat", c, 8);
    b0.dado_a = 7'b0101010;
    b0.dado_b = 7'b1110001;
    b0.req_a = 1'b1;
    b0.req_b = 1'b1;
    for (int i = 0; i < 4; i++) exp0.push_back(i % 2 == 0 ? {1'b0, 7'b0101010} : {1'b1, 7'b1110001});
    for (int i = 0; i < 4; i++) begin
      espera(4, 30, c);
      chk("t3_rr", b0.ack_b, i % 2);
    end
    b0.req_a = 1'b0;
    b0.req_b = 1'b0;
    espera(3, 30, c);
    b0.dado_a = 7'b1111111;
    b0.req_a = 1'b1;
    espera(0, 10, c);
    b0.req_a = 1'b0;
    repeat (4) step();
    chk("t4_desloca3", sv_0, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t4_ocioso", oc_0, 0);
    chk("t4_modo", {ch1_0, ch0_0}, 0);
    chk("t4_valid", sv_0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("t4_sem_fim", b0.fim_a | b0.fim_b, 0);
      step();
    end
    b0.dado_b = 7'b1000110;
    b0.req_b = 1'b1;
    exp0.push_back({1'b1, 7'b1000110});
    espera(1, 5, c);
    chk("t4_ack_b_lat", c, 1);
    b0.req_b = 1'b0;
    espera(3, 20, c);
    chk("t4_fim_b_lat", c, 8);
    b0.dado_a = 7'b0011010;
    b0.req_a = 1'b1;
    exp0.push_back({1'b0, 7'b0011010});
    espera(0, 10, c);
    b0.req_a = 1'b0;
    repeat (2) step();
    b0.dado_b = 7'b0110011;
    b0.req_b = 1'b1;
    exp0.push_back({1'b1, 7'b0110011});
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      step();
      chk("t6_ack_b_cedo", b0.ack_b, 0);
      hit = b0.fim_a;
    end
    chk("t6_fim_a", hit, 1);
    espera(1, 5, c);
    chk("t6_ack_b_apos_fim", c, 2);
    b0.req_b = 1'b0;
    espera(3, 20, c);
    b3.dado_a = 7'b1010101;
    b3.req_a = 1'b1;
    c = 0;
    while (!b3.ack_a && c < 10) begin
      step();
      c++;
    end
    chk("t5_ack1", b3.ack_a, 1);
    c = 0;
    while (!b3.fim_a && c < 20) begin
      step();
      c++;
    end
    chk("t5_fim", b3.fim_a, 1);
    c = 0;
    np = 0;
    do begin
      step();
      c++;
      if (oc_3 && {ch1_3, ch0_3} == MODO_HOLD && !b3.ack_a) np++;
    end while (!b3.ack_a && c < 20);
    b3.req_a = 1'b0;
    chk("t5_ack2", b3.ack_a, 1);
    chk("t5_gap", c, 5);
    chk("t5_pausa_ocupado", np, 3);
    repeat (12) step();
    chk("fila_final", exp0.size(), 0);
    chk("modo_11", bad_modo, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
